param_mux_scanner: RTL and testbench

//  Registered N:1 channel selector, W bits per channel; generalised successor to the 8:1 switch mux.

---
 rtl/param_mux_scanner.sv | 108 ++++++++++
 tb/tb_param_mux_scanner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/param_mux_scanner.sv
// Registered N:1 channel selector with manual, auto-scan, single-step and hold modes.
// The channel pointer and its data are registered on the same edge, so dout always matches cur_ch.
module param_mux_scanner #(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int SELW  = $clog2(N),
    parameter int DWELL = 50
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [N*W-1:0]  data_in,
    input  logic [SELW-1:0] sel_n,
    input  logic [1:0]      mode,
    input  logic            step_n,
    output logic [W-1:0]    dout,
    output logic [SELW-1:0] cur_ch,
    output logic            ch_strobe,
    output logic            sel_err
);
    localparam int CW = $clog2(DWELL) + 1;

    typedef enum logic [1:0] {
        M_MANUAL = 2'b00,
        M_AUTO   = 2'b01,
        M_STEP   = 2'b10,
        M_HOLD   = 2'b11
    } mode_e;

    logic [SELW-1:0] r_ptr;
    logic [W-1:0]    r_dout;
    logic            r_strobe;
    logic            r_err;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_mode;
    logic            r_s1, r_s2, r_prev;

    logic [SELW-1:0] w_idx;
    logic            w_oor;
    logic [SELW-1:0] w_inc;
    logic            w_mode_chg;
    logic            w_step_edge;
    logic [SELW-1:0] w_next;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_err;
    logic [W-1:0]    w_dout;

    always_comb begin
        w_idx       = ~sel_n;
        w_oor       = {1'b0, w_idx} >= (SELW+1)'(N);
        // explicit wrap so non-power-of-two N never reaches an unused index
        w_inc       = (r_ptr == SELW'(N-1)) ? '0 : r_ptr + 1'b1;
        w_mode_chg  = (mode != r_mode);
        w_step_edge = r_prev & ~r_s2;
        w_next      = r_ptr;
        w_cnt_nxt   = '0;
        w_err       = 1'b0;
        case (mode_e'(mode))
            M_MANUAL: begin
                if (w_oor) w_err  = 1'b1;
                else       w_next = w_idx;
            end
            M_AUTO: begin
                if (w_mode_chg)
                    w_cnt_nxt = '0;
                else if (r_cnt == CW'(DWELL-1)) begin
                    w_next    = w_inc;
                    w_cnt_nxt = '0;
                end else
                    w_cnt_nxt = r_cnt + 1'b1;
            end
            M_STEP: begin
                if (w_step_edge) w_next = w_inc;
            end
            default: ;
        endcase
        w_dout = w_err ? '0 : data_in[int'(w_next)*W +: W];
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_ptr    <= '0;
            r_dout   <= '0;
            r_strobe <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            // tracking the live mode through reset lets a scan start counting on the first cycle out
            r_mode   <= mode;
            r_s1     <= 1'b1;
            r_s2     <= 1'b1;
            r_prev   <= 1'b1;
        end else begin
            r_ptr    <= w_next;
            r_dout   <= w_dout;
            r_strobe <= (w_next != r_ptr);
            r_err    <= w_err;
            r_cnt    <= w_cnt_nxt;
            r_mode   <= mode;
            r_s1     <= step_n;
            r_s2     <= r_s1;
            r_prev   <= r_s2;
        end
    end

    assign dout      = r_dout;
    assign cur_ch    = r_ptr;
    assign ch_strobe = r_strobe;
    assign sel_err   = r_err;
endmodule

// File: tb/tb_param_mux_scanner.sv
// Directed bench: uA is N=8,W=1,DWELL=4; uB is N=5,W=2,DWELL=50.
module tb_param_mux_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_step;
    logic [7:0] a_data;
    logic [2:0] a_sel;
    logic [1:0] a_mode;
    logic [0:0] a_dout;
    logic [2:0] a_ch;
    logic       a_stb, a_err;

    logic       b_rst, b_step;
    logic [9:0] b_data;
    logic [2:0] b_sel;
    logic [1:0] b_mode;
    logic [1:0] b_dout;
    logic [2:0] b_ch;
    logic       b_stb, b_err;

    int n_tests = 0;
    int n_fail  = 0;

    param_mux_scanner #(.N(8), .W(1), .SELW(3), .DWELL(4)) uA (
        .CLOCK_50(clk), .reset(a_rst), .data_in(a_data), .sel_n(a_sel), .mode(a_mode),
        .step_n(a_step), .dout(a_dout), .cur_ch(a_ch), .ch_strobe(a_stb), .sel_err(a_err));

    param_mux_scanner #(.N(5), .W(2), .SELW(3), .DWELL(50)) uB (
        .CLOCK_50(clk), .reset(b_rst), .data_in(b_data), .sel_n(b_sel), .mode(b_mode),
        .step_n(b_step), .dout(b_dout), .cur_ch(b_ch), .ch_strobe(b_stb), .sel_err(b_err));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1; a_step = 1; a_data = 8'hA5; a_sel = 3'b111; a_mode = 2'b00;
        b_rst = 1; b_step = 1; b_data = '0; b_sel = 3'b111; b_mode = 2'b00;

        // 1: manual select ch0 then ch7
        tick();
        chk("rst_dout", 32'(a_dout), 32'd0);
        chk("rst_ch", 32'(a_ch), 32'd0);
        chk("rst_stb", 32'(a_stb), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        a_rst = 0;
        tick();
        chk("m_ch0_dout", 32'(a_dout), 32'd1);
        chk("m_ch0_stb", 32'(a_stb), 32'd0);
        a_sel = 3'b000;
        tick();
        chk("m_ch7", 32'(a_ch), 32'd7);
        chk("m_ch7_dout", 32'(a_dout), 32'd1);
        chk("m_ch7_stb", 32'(a_stb), 32'd1);
        tick();
        chk("m_ch7_stb_once", 32'(a_stb), 32'd0);

        // 2: auto-scan DWELL=4 from reset, full lap with wrap
        a_rst = 1; a_mode = 2'b01;
        tick();
        a_rst = 0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            chk($sformatf("as_ch%0d", k), 32'(a_ch), 32'((k / 4) % 8));
            chk($sformatf("as_stb%0d", k), 32'(a_stb), 32'((k % 4) == 0));
            chk($sformatf("as_dout%0d", k), 32'(a_dout), 32'(a_data[(k / 4) % 8]));
        end

        // 3: N=5 out-of-range manual select
        b_data = 10'b01_00_11_10_01;
        b_sel = ~3'd1;
        tick();
        b_rst = 0;
        tick();
        chk("oor_pre_ch", 32'(b_ch), 32'd1);
        chk("oor_pre_dout", 32'(b_dout), 32'd2);
        b_sel = ~3'd6;
        tick();
        chk("oor_err", 32'(b_err), 32'd1);
        chk("oor_dout", 32'(b_dout), 32'd0);
        chk("oor_ch", 32'(b_ch), 32'd1);
        chk("oor_stb", 32'(b_stb), 32'd0);
        b_sel = ~3'd2;
        tick();
        chk("oor_clr_err", 32'(b_err), 32'd0);
        chk("oor_clr_ch", 32'(b_ch), 32'd2);
        chk("oor_clr_dout", 32'(b_dout), 32'd3);
        chk("oor_clr_stb", 32'(b_stb), 32'd1);
        b_sel = ~3'd5;
        tick();
        chk("oor5_err", 32'(b_err), 32'd1);
        b_mode = 2'b11;
        tick();
        chk("oor_hold_err", 32'(b_err), 32'd0);
        chk("oor_hold_ch", 32'(b_ch), 32'd2);
        chk("oor_hold_dout", 32'(b_dout), 32'd3);

        // 4: step mode, two presses advance exactly two; hold-mode presses ignored
        a_rst = 1; a_mode = 2'b10;
        tick();
        a_rst = 0;
        for (int p = 1; p <= 2; p++) begin
            a_step = 0;
            tick(2);
            chk($sformatf("st%0d_e2", p), 32'(a_ch), 32'(p - 1));
            tick();
            chk($sformatf("st%0d_e3", p), 32'(a_ch), 32'(p));
            chk($sformatf("st%0d_stb", p), 32'(a_stb), 32'd1);
            tick(7);
            chk($sformatf("st%0d_low", p), 32'(a_ch), 32'(p));
            a_step = 1;
            tick(10);
            chk($sformatf("st%0d_rel", p), 32'(a_ch), 32'(p));
        end
        a_mode = 2'b11;
        a_step = 0;
        tick(10);
        a_step = 1;
        tick(10);
        chk("st_hold", 32'(a_ch), 32'd2);
        a_mode = 2'b10;
        tick(5);
        chk("st_back", 32'(a_ch), 32'd2);

        // 5: reset mid-scan on ch3 at count 20
        b_data = 10'b11_10_01_11_01;
        b_rst = 1; b_mode = 2'b01;
        tick();
        b_rst = 0;
        tick(170);
        chk("rs_pre_ch", 32'(b_ch), 32'd3);
        b_rst = 1;
        tick();
        chk("rs_ch", 32'(b_ch), 32'd0);
        chk("rs_dout", 32'(b_dout), 32'd0);
        chk("rs_stb", 32'(b_stb), 32'd0);
        b_rst = 0;
        tick(49);
        chk("rs_49_ch", 32'(b_ch), 32'd0);
        chk("rs_49_dout", 32'(b_dout), 32'd1);
        tick();
        chk("rs_50_ch", 32'(b_ch), 32'd1);
        chk("rs_50_stb", 32'(b_stb), 32'd1);
        chk("rs_50_dout", 32'(b_dout), 32'd3);

        // 6: hold mode, data toggles propagate, pointer frozen
        a_rst = 1; a_mode = 2'b00; a_sel = ~3'd5;
        tick();
        a_rst = 0;
        tick();
        chk("h_setup_ch", 32'(a_ch), 32'd5);
        a_mode = 2'b11; a_sel = 3'b111;
        tick();
        chk("h_ch", 32'(a_ch), 32'd5);
        chk("h_dout", 32'(a_dout), 32'd1);
        a_data = 8'h85;
        tick();
        chk("h_tog_dout", 32'(a_dout), 32'd0);
        chk("h_tog_ch", 32'(a_ch), 32'd5);
        chk("h_tog_stb", 32'(a_stb), 32'd0);
        a_data = 8'hA5;
        tick();
        chk("h_back_dout", 32'(a_dout), 32'd1);
        chk("h_back_stb", 32'(a_stb), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
